// File: rtl/systolic_gemm_ctrl.sv
// rtl/systolic_gemm_ctrl.sv - sequencer for one output-stationary ROWS x COLS GEMM tile
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, k_len   job request (sampled in IDLE) and reduction depth
//   abort          synchronous abort, any state returns to IDLE
//   busy, done     job in progress (CLEAR..READ), one-cycle completion pulse
//   arr_clear      accumulator clear to every PE
//   buf_rd_en      operand buffer read strobe, buf_rd_k is the k-index read
//   acc_row_sel    result row driven onto the result bus
//   out_valid      result row valid, out_ready accepts it, out_last marks row ROWS-1
module systolic_gemm_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 256,
  parameter int K_W    = $clog2(K_MAX + 1),
  parameter int RD_LAT = 1,
  parameter int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             arr_clear,
  output logic             buf_rd_en,
  output logic [K_W-1:0]   buf_rd_k,
  output logic [ROW_W-1:0] acc_row_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  // Last operand needs RD_LAT to leave the buffer, ROWS-1 row skew plus
  // COLS-1 column hops to reach the far corner PE, and one more cycle for
  // that PE's accumulator register to capture it.
  localparam int DRAIN_CYC = RD_LAT + ROWS + COLS - 1;
  localparam int DR_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [K_W-1:0]   K_SAT    = K_W'(K_MAX);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DRAIN_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [K_W-1:0]   k_lat;
  logic [K_W-1:0]   k_cnt;
  logic [DR_W-1:0]  dr_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             k_last;
  logic             dr_last;
  logic             row_last;

  // k_lat is at least 1 whenever FEED is active, so k_lat-1 never underflows there.
  assign k_last   = (k_cnt == k_lat - K_W'(1));
  assign dr_last  = (dr_cnt == DR_LAST);
  assign row_last = (row_cnt == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k_lat   <= '0;
      k_cnt   <= '0;
      dr_cnt  <= '0;
      row_cnt <= '0;
    end else begin
      state <= state_nx;

      if (abort) begin
        k_lat <= '0;
      end else if (state == S_IDLE && start) begin
        k_lat <= (k_len > K_SAT) ? K_SAT : k_len;
      end

      // Each counter idles at zero outside its own state, so it starts
      // from zero on entry and holds its final value on the exit cycle.
      if (abort || state != S_FEED) begin
        k_cnt <= '0;
      end else if (!k_last) begin
        k_cnt <= k_cnt + K_W'(1);
      end

      if (abort || state != S_DRAIN) begin
        dr_cnt <= '0;
      end else if (!dr_last) begin
        dr_cnt <= dr_cnt + DR_W'(1);
      end

      if (abort || state != S_READ) begin
        row_cnt <= '0;
      end else if (out_ready && !row_last) begin
        row_cnt <= row_cnt + ROW_W'(1);
      end
    end
  end

  // Outputs decode only registered state and counters; out_ready steers
  // the next state but never feeds an output directly.
  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    arr_clear   = 1'b0;
    buf_rd_en   = 1'b0;
    buf_rd_k    = '0;
    acc_row_sel = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        busy      = 1'b1;
        arr_clear = 1'b1;
        state_nx  = (k_lat != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        busy      = 1'b1;
        buf_rd_en = 1'b1;
        buf_rd_k  = k_cnt;
        if (k_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (dr_last) state_nx = S_READ;
      end
      S_READ: begin
        busy        = 1'b1;
        out_valid   = 1'b1;
        acc_row_sel = row_cnt;
        out_last    = row_last;
        if (out_ready && row_last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (abort) state_nx = S_IDLE;
  end

endmodule

// File: tb/tb_systolic_gemm_ctrl.sv
// tb/tb_systolic_gemm_ctrl.sv - directed bench for systolic_gemm_ctrl with a 4x4 PE array model
module tb_systolic_gemm_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int K_MAX = 256;
  localparam int K_W   = 9;
  localparam int ROW_W = 2;
  localparam int KE    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b0;
  logic [K_W-1:0]   k_len = '0;
  logic             busy;
  logic             done;
  logic             arr_clear;
  logic             buf_rd_en;
  logic [K_W-1:0]   buf_rd_k;
  logic [ROW_W-1:0] acc_row_sel;
  logic             out_valid;
  logic             out_last;

  systolic_gemm_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .K_W(K_W), .RD_LAT(1), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .arr_clear(arr_clear), .buf_rd_en(buf_rd_en),
    .buf_rd_k(buf_rd_k), .acc_row_sel(acc_row_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Operand buffers, skew registers and output-stationary PE array.
  int a_mat [ROWS][KE];
  int b_mat [KE][COLS];
  int gold  [ROWS][COLS];
  logic           rd_v_q = 1'b0;
  logic [K_W-1:0] rd_k_q = '0;
  int a_col [ROWS];
  int b_row [COLS];
  int a_sk  [ROWS];
  int b_sk  [COLS];
  int a_dl  [ROWS][ROWS];
  int b_dl  [COLS][COLS];
  int a_reg [ROWS][COLS];
  int b_reg [ROWS][COLS];
  int a_in  [ROWS][COLS];
  int b_in  [ROWS][COLS];
  int acc   [ROWS][COLS];

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_col[i] = rd_v_q ? a_mat[i][rd_k_q[2:0]] : 0;
      if (i == 0) a_sk[i] = a_col[i];
      else        a_sk[i] = a_dl[i][i-1];
    end
    for (int j = 0; j < COLS; j++) begin
      b_row[j] = rd_v_q ? b_mat[rd_k_q[2:0]][j] : 0;
      if (j == 0) b_sk[j] = b_row[j];
      else        b_sk[j] = b_dl[j][j-1];
    end
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (j == 0) a_in[i][j] = a_sk[i];
        else        a_in[i][j] = a_reg[i][j-1];
        if (i == 0) b_in[i][j] = b_sk[j];
        else        b_in[i][j] = b_reg[i-1][j];
      end
    end
  end

  always @(posedge clk) begin
    rd_v_q <= buf_rd_en;
    rd_k_q <= buf_rd_k;
    for (int i = 0; i < ROWS; i++) begin
      a_dl[i][0] <= a_col[i];
      for (int d = 1; d < ROWS; d++) a_dl[i][d] <= a_dl[i][d-1];
    end
    for (int j = 0; j < COLS; j++) begin
      b_dl[j][0] <= b_row[j];
      for (int d = 1; d < COLS; d++) b_dl[j][d] <= b_dl[j][d-1];
    end
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        a_reg[i][j] <= a_in[i][j];
        b_reg[i][j] <= b_in[i][j];
        acc[i][j]   <= arr_clear ? 0 : acc[i][j] + a_in[i][j] * b_in[i][j];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge of CLEAR.
  task automatic start_job(input int k);
    start = 1'b1;
    k_len = K_W'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Steps cycles until out_valid, counting read strobes; cyc starts at 1 (CLEAR).
  task automatic wait_valid(output int cyc, output int nrd, output int lastk);
    cyc = 1; nrd = 0; lastk = -1;
    while (!out_valid && cyc < 500) begin
      if (buf_rd_en) begin
        nrd++;
        lastk = int'(buf_rd_k);
      end
      @(negedge clk);
      cyc++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  // Drains result rows with out_ready=1; mode 1 expects zero rows, mode 2 the golden product.
  task automatic read_rows(input int mode);
    int r = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (out_valid) begin
        chk($sformatf("row_sel_%0d", r), acc_row_sel, r);
        chk($sformatf("row_last_%0d", r), out_last, (r == ROWS - 1));
        for (int j = 0; j < COLS; j++) begin
          if (mode == 1) chk($sformatf("zero_r%0d_c%0d", r, j), acc[acc_row_sel][j], 0);
          if (mode == 2) chk($sformatf("gemm_r%0d_c%0d", r, j), acc[acc_row_sel][j], gold[r][j]);
        end
        r++;
      end
      @(negedge clk);
    end
    chk("rows_done", done, 1);
    chk("rows_cnt", r, ROWS);
  endtask

  initial begin
    int cyc, nrd, lastk, hs, er;
    logic eb, ed, ec, er_en, ev, el;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hold", {busy, done, arr_clear, buf_rd_en, out_valid, out_last, buf_rd_k, acc_row_sel}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", {busy, done, arr_clear, buf_rd_en, out_valid, out_last, buf_rd_k, acc_row_sel}, 0);

    // Basic job k=3 with out_ready held high: cycle-exact schedule
    out_ready = 1'b1;
    start_job(3);
    for (int c = 1; c <= 18; c++) begin
      eb    = (c >= 1 && c <= 16);
      ed    = (c == 17);
      ec    = (c == 1);
      er_en = (c >= 2 && c <= 4);
      ev    = (c >= 13 && c <= 16);
      el    = (c == 16);
      chk($sformatf("t1_ctl_c%0d", c), {busy, done, arr_clear, buf_rd_en, out_valid, out_last},
          {eb, ed, ec, er_en, ev, el});
      chk($sformatf("t1_k_c%0d", c), buf_rd_k, er_en ? c - 2 : 0);
      chk($sformatf("t1_row_c%0d", c), acc_row_sel, ev ? c - 13 : 0);
      @(negedge clk);
    end

    // Backpressure: ready low 13-15, then toggled
    out_ready = 1'b0;
    start_job(3);
    wait_valid(cyc, nrd, lastk);
    chk("bp_first_valid", cyc, 13);
    chk("bp_nrd", nrd, 3);
    hs = 0; er = 0;
    while (hs < ROWS && cyc < 60) begin
      chk($sformatf("bp_valid_c%0d", cyc), out_valid, 1);
      chk($sformatf("bp_row_c%0d", cyc), acc_row_sel, er);
      chk($sformatf("bp_last_c%0d", cyc), out_last, (er == ROWS - 1));
      out_ready = (cyc >= 16) ? cyc[0] : 1'b0;
      if (out_ready) begin
        hs++;
        er++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("bp_handshakes", hs, ROWS);
    chk("bp_done", {done, busy}, 2'b10);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_pulse", {done, busy}, 2'b00);

    // Saturation: k_len above K_MAX
    start_job(K_MAX + 5);
    wait_valid(cyc, nrd, lastk);
    chk("sat_nrd", nrd, K_MAX);
    chk("sat_lastk", lastk, K_MAX - 1);
    read_rows(0);
    @(negedge clk);

    // Zero length: straight to drain, all-zero rows
    start_job(0);
    wait_valid(cyc, nrd, lastk);
    chk("zero_nrd", nrd, 0);
    chk("zero_first_valid", cyc, 10);
    read_rows(1);
    @(negedge clk);

    // Abort mid-FEED after k=1 is issued
    start_job(5);
    @(negedge clk);
    @(negedge clk);
    chk("ab_k1", {buf_rd_en, buf_rd_k}, {1'b1, 9'd1});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_after", {busy, buf_rd_en, done, arr_clear}, 0);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("ab_idle_%0d", n), {busy, done}, 0);
      @(negedge clk);
    end
    start_job(2);
    wait_valid(cyc, nrd, lastk);
    chk("ab_next_nrd", nrd, 2);
    read_rows(0);
    @(negedge clk);

    // Start while busy is ignored and not queued
    start_job(1);
    start = 1'b1;
    k_len = 9'd7;
    nrd = 0;
    for (int n = 0; n < 5; n++) begin
      if (buf_rd_en) nrd++;
      @(negedge clk);
    end
    start = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (buf_rd_en) nrd++;
      @(negedge clk);
    end
    chk("busy_start_done", done, 1);
    chk("busy_start_nrd", nrd, 1);
    @(negedge clk);
    chk("busy_start_noq0", {busy, arr_clear}, 0);
    @(negedge clk);
    chk("busy_start_noq1", {busy, arr_clear}, 0);

    // start and abort together in IDLE: no job
    start = 1'b1;
    abort = 1'b1;
    k_len = 9'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("st_ab_0", {busy, arr_clear}, 0);
    @(negedge clk);
    chk("st_ab_1", {busy, arr_clear, buf_rd_en}, 0);

    // Asynchronous reset during READ
    out_ready = 1'b0;
    start_job(2);
    wait_valid(cyc, nrd, lastk);
    #2 rst_n = 1'b0;
    #1 chk("arst_now", {out_valid, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_idle", {busy, done, out_valid, arr_clear}, 0);

    // End-to-end GEMM through the PE array model
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < KE; k++) a_mat[i][k] = int'($urandom_range(0, 15));
    for (int k = 0; k < KE; k++)
      for (int j = 0; j < COLS; j++) b_mat[k][j] = int'($urandom_range(0, 15));
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        gold[i][j] = 0;
        for (int k = 0; k < KE; k++) gold[i][j] += a_mat[i][k] * b_mat[k][j];
      end
    start_job(KE);
    wait_valid(cyc, nrd, lastk);
    chk("e2e_nrd", nrd, KE);
    read_rows(2);

    // Back-to-back: start in the IDLE cycle right after DONE
    @(negedge clk);
    start_job(0);
    chk("b2b_clear", {arr_clear, busy}, 2'b11);
    for (int n = 0; n < 40 && !done; n++) @(negedge clk);
    chk("b2b_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_gemm_ctrl.md
Name: systolic_gemm_ctrl

Overview:
- Sequencer for one output-stationary ROWS x COLS GEMM tile on the PE array.
- Accepts a job (K depth) and pulses the array accumulator clear.
- Streams K operand slices from the A/B operand buffers into the external skew registers, then waits for the wavefront to drain.
- Reads the accumulated result rows out over a valid/ready handshake, then signals done.

Parameters:
- ROWS, 4, PE array rows (A lanes, result rows).
- COLS, 4, PE array columns (B lanes).
- K_MAX, 256, maximum reduction depth per job.
- K_W, $clog2(K_MAX+1), width of k_len and k-index.
- RD_LAT, 1, operand buffer read latency in cycles (>=0).
- ROW_W, $clog2(ROWS) (min 1), width of result row select.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  K_W  reduction depth; latched on accepted start.
- abort  in  1  synchronous abort; any state -> IDLE.
- busy  out  1  high from CLEAR through READ.
- done  out  1  one-cycle pulse after the last result row handshake.
- arr_clear  out  1  drives clear of every PE.
- buf_rd_en  out  1  operand buffer read strobe (A column k and B row k).
- buf_rd_k  out  K_W  operand k-index for buf_rd_en.
- acc_row_sel  out  ROW_W  selects the result row driven onto the result bus.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts result row.
- out_last  out  1  high with out_valid on row ROWS-1.

Behaviour:
- Reset state:
  - State IDLE.
  - All outputs 0; internal counters 0.
- States and transitions:
  - IDLE -> CLEAR on start. k_len latched, saturated to K_MAX if larger.
  - CLEAR: one cycle, arr_clear=1. Next state is FEED if latched k>0; else DRAIN.
  - FEED:
    - Exactly k cycles with buf_rd_en=1.
    - buf_rd_k = 0,1,..,k-1, one per cycle.
    - Transition to DRAIN after the cycle issuing k-1.
  - DRAIN: D = RD_LAT + ROWS + COLS - 1 cycles, all strobes 0. This covers the last operand reaching PE(ROWS-1,COLS-1) through row skew i plus column hop j, plus one cycle for the accumulator register to update. Then READ.
  - READ:
    - out_valid=1, acc_row_sel=r, starting at r=0.
    - r advances only on the out_valid & out_ready cycle.
    - out_valid, acc_row_sel and out_last are held stable while out_ready=0.
    - out_last = (r==ROWS-1).
    - After the handshake on r=ROWS-1, go to DONE.
  - DONE: one cycle, done=1, busy=0, then IDLE.
- Handshake and input rules:
  - start while not in IDLE is ignored; it is not queued.
  - start and abort in the same IDLE cycle: abort wins, no job is accepted.
  - k_len changes after acceptance have no effect.
  - k=0 job: CLEAR -> DRAIN -> READ, producing ROWS all-zero rows.
- Output timing:
  - All outputs are registered or decoded from registered state; no combinational path from out_ready to out_valid.
  - arr_clear and buf_rd_en are never high in the same cycle.
- Abort:
  - Abort in any state: next cycle IDLE, all outputs 0, no done pulse.
  - Partial accumulator contents are undefined; the next job clears them.
- Counters:
  - k counter K_W bits, no wrap; it stops at k-1.
  - Drain counter sized for D. Row counter ROW_W bits, reset to 0 on entering READ.
- Back-to-back jobs: start may be asserted in the IDLE cycle directly after DONE; the new job is accepted that cycle.
- Asynchronous reset mid-job behaves like abort but is immediate, including the register clear.

Test Plan:
- Basic job, ROWS=COLS=4, RD_LAT=1, k_len=3, start at cycle 0:
  - arr_clear cycle 1; buf_rd_en cycles 2-4 with buf_rd_k=0,1,2.
  - Drain cycles 5-12; out_valid from cycle 13.
  - With out_ready=1: rows 0..3 on cycles 13-16, out_last at 16, done at 17, busy low at 17.
- Backpressure: same job, out_ready low cycles 13-15 and toggled thereafter -> acc_row_sel and out_valid stable while stalled; exactly 4 handshakes, rows in order 0..3, done one cycle after the row-3 handshake.
- Saturation and zero length:
  - k_len=K_MAX+5 (K_W allows) -> exactly K_MAX read strobes, last buf_rd_k=K_MAX-1.
  - k_len=0 -> no buf_rd_en; 4 rows read out after the 8-cycle drain.
- Abort mid-FEED after buf_rd_k=1 -> next cycle busy=0 and buf_rd_en=0, no done; a following job (k_len=2) completes normally.
- Start ignored while busy, start+abort in IDLE ignored; asynchronous reset asserted during READ -> out_valid and busy 0 immediately.
- End-to-end: controller plus 4x4 pe_systolic array plus skew buffers, random A(4x8) and B(8x4) -> read rows equal the golden A*B.
